// File: rtl/ad7606_conv_ctrl.sv
// AD7606 conversion controller: resets the ADC, issues periodic CONVST
// pulses, waits for BUSY, starts the parallel read stage and counts frames.
// Optional watchdog on the BUSY/read waits is compiled in with the macro
// AD7606_BUSY_TIMEOUT_EN; without it timeout_o is tied low.
module ad7606_conv_ctrl #(
  parameter int RESET_CYCLES      = 4,
  parameter int CONVST_LOW_CYCLES = 2,
  parameter int SAMPLE_DIV        = 1000,
  parameter int BUSY_TIMEOUT      = 4096
) (
  input  logic        sys_clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic [2:0]  os_i,
  output logic [2:0]  os_o,
  output logic        ad_reset_o,
  output logic        ad_convst_o,
  input  logic        ad_busy_i,
  output logic        spi_start_flag_o,
  input  logic        data_flag_i,
  output logic [15:0] frame_cnt_o,
  output logic        overrun_o,
  output logic        timeout_o
);

  localparam int RstW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int CvW  = (CONVST_LOW_CYCLES > 1) ? $clog2(CONVST_LOW_CYCLES) : 1;
  localparam int PerW = $clog2(SAMPLE_DIV);

  localparam logic [RstW-1:0] RstLast = RstW'(RESET_CYCLES - 1);
  localparam logic [CvW-1:0]  CvLast  = CvW'(CONVST_LOW_CYCLES - 1);
  localparam logic [PerW-1:0] PerLast = PerW'(SAMPLE_DIV - 1);

  typedef enum logic [2:0] {
    ST_RST,
    ST_IDLE,
    ST_CONV,
    ST_WAIT_BH,
    ST_WAIT_BL,
    ST_READ,
    ST_WAIT_PER
  } state_t;

  state_t          r_state;
  logic [RstW-1:0] r_rst_cnt;
  logic [CvW-1:0]  r_cv_cnt;
  logic [PerW-1:0] r_per_cnt;
  logic [15:0]     r_frame_cnt;
  logic [2:0]      r_os;
  logic            r_ad_reset;
  logic            r_convst;
  logic            r_spi_start;
  logic            r_overrun;
  logic            r_busy_meta;
  logic            r_busy_s;

  logic w_per_wrap;
  logic w_in_frame;

  assign w_per_wrap = (r_per_cnt == PerLast);
  assign w_in_frame = (r_state == ST_CONV) || (r_state == ST_WAIT_BH) ||
                      (r_state == ST_WAIT_BL) || (r_state == ST_READ);

`ifdef AD7606_BUSY_TIMEOUT_EN
  localparam int WdW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(BUSY_TIMEOUT - 1);

  logic [WdW-1:0] r_wd_cnt;
  logic           r_timeout;
  logic           w_wd_state;
  logic           w_wd_hit;

  assign w_wd_state = (r_state == ST_WAIT_BH) || (r_state == ST_WAIT_BL) ||
                      (r_state == ST_READ);
  assign w_wd_hit   = w_wd_state && (r_wd_cnt == WdLast);
  assign timeout_o  = r_timeout;
`else
  logic w_unused_wd;
  assign w_unused_wd = (BUSY_TIMEOUT > 0);
  assign timeout_o   = 1'b0;
`endif

  // Two-flop synchronizer bringing the ADC BUSY pin into the sys_clk_i domain
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_busy_meta <= 1'b0;
      r_busy_s    <= 1'b0;
    end else begin
      r_busy_meta <= ad_busy_i;
      r_busy_s    <= r_busy_meta;
    end
  end

  // Conversion sequencer with registered pin outputs, period counter and frame counter
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_RST;
      r_rst_cnt   <= '0;
      r_cv_cnt    <= '0;
      r_per_cnt   <= '0;
      r_frame_cnt <= '0;
      r_os        <= '0;
      r_ad_reset  <= 1'b1;
      r_convst    <= 1'b1;
      r_spi_start <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef AD7606_BUSY_TIMEOUT_EN
      r_wd_cnt    <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_spi_start <= 1'b0;

      if (w_per_wrap) begin
        r_per_cnt <= '0;
      end else begin
        r_per_cnt <= r_per_cnt + PerW'(1);
      end

      if (w_per_wrap && w_in_frame) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        ST_RST: begin
          if (r_rst_cnt == RstLast) begin
            r_state    <= ST_IDLE;
            r_ad_reset <= 1'b0;
            r_overrun  <= 1'b0;
            r_rst_cnt  <= '0;
          end else begin
            r_rst_cnt <= r_rst_cnt + RstW'(1);
          end
        end
        ST_IDLE: begin
          r_os <= os_i;
          if (enable_i) begin
            r_state   <= ST_CONV;
            r_convst  <= 1'b0;
            r_cv_cnt  <= '0;
            r_per_cnt <= '0;
          end
        end
        ST_CONV: begin
          if (r_cv_cnt == CvLast) begin
            r_state  <= ST_WAIT_BH;
            r_convst <= 1'b1;
          end else begin
            r_cv_cnt <= r_cv_cnt + CvW'(1);
          end
        end
        ST_WAIT_BH: begin
          if (r_busy_s) begin
            r_state <= ST_WAIT_BL;
          end
        end
        ST_WAIT_BL: begin
          if (!r_busy_s) begin
            r_state     <= ST_READ;
            r_spi_start <= 1'b1;
          end
        end
        ST_READ: begin
          if (data_flag_i) begin
            r_state     <= ST_WAIT_PER;
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end
        end
        ST_WAIT_PER: begin
          if (!enable_i) begin
            r_state   <= ST_IDLE;
            r_overrun <= 1'b0;
          end else if (w_per_wrap) begin
            r_state  <= ST_CONV;
            r_convst <= 1'b0;
            r_cv_cnt <= '0;
          end
        end
        default: begin
          r_state    <= ST_RST;
          r_ad_reset <= 1'b1;
          r_convst   <= 1'b1;
          r_rst_cnt  <= '0;
        end
      endcase

`ifdef AD7606_BUSY_TIMEOUT_EN
      r_timeout <= 1'b0;
      if (w_wd_state) begin
        r_wd_cnt <= r_wd_cnt + WdW'(1);
      end else begin
        r_wd_cnt <= '0;
      end
      if (w_wd_hit) begin
        r_state     <= ST_RST;
        r_ad_reset  <= 1'b1;
        r_rst_cnt   <= '0;
        r_spi_start <= 1'b0;
        r_frame_cnt <= r_frame_cnt;
        r_timeout   <= 1'b1;
        r_wd_cnt    <= '0;
      end
`endif
    end
  end

  assign os_o             = r_os;
  assign ad_reset_o       = r_ad_reset;
  assign ad_convst_o      = r_convst;
  assign spi_start_flag_o = r_spi_start;
  assign frame_cnt_o      = r_frame_cnt;
  assign overrun_o        = r_overrun;

endmodule

// File: tb/tb_ad7606_conv_ctrl.sv
// Testbench for ad7606_conv_ctrl: ADC and read-stage models drive the DUT,
// a monitor turns DUT output activity into timed events that are scored
// against a queue of hand-computed expectations pushed by the stimulus.
module tb_ad7606_conv_ctrl;

  localparam int ResetCycles = 4;
  localparam int ConvstLow   = 2;
  localparam int SampleDiv   = 100;
  localparam int BusyTimeout = 50;

  typedef enum int {EV_ADRST, EV_CVLOW, EV_CVPER, EV_START, EV_FRAME, EV_TMO} evKind_t;
  typedef struct {
    evKind_t kind;
    int      value;
  } expect_t;

  logic        clock    = 1'b0;
  logic        rstN     = 1'b0;
  logic        enable   = 1'b0;
  logic [2:0]  osIn     = 3'b000;
  logic        adBusy   = 1'b0;
  logic        dataFlag = 1'b0;
  logic [2:0]  osOut;
  logic        adReset;
  logic        adConvst;
  logic        spiStart;
  logic [15:0] frameCnt;
  logic        overrun;
  logic        timeout;

  int      checks     = 0;
  int      errors     = 0;
  int      cyc        = 0;
  int      readDelay  = 40;
  bit      busyEnable = 1'b0;
  expect_t scoreQ[$];

  bit prevConvst  = 1'b1;
  bit prevBusy    = 1'b0;
  bit prevSpi     = 1'b0;
  bit prevTmo     = 1'b0;
  int prevFrame   = 0;
  bit arCounting  = 1'b0;
  bit periodValid = 1'b0;
  int arStart     = 0;
  int lastFall    = 0;
  int lastRise    = 0;
  int busyFall    = 0;

  ad7606_conv_ctrl #(
    .RESET_CYCLES      (ResetCycles),
    .CONVST_LOW_CYCLES (ConvstLow),
    .SAMPLE_DIV        (SampleDiv),
    .BUSY_TIMEOUT      (BusyTimeout)
  ) dut (
    .sys_clk_i        (clock),
    .rst_n_i          (rstN),
    .enable_i         (enable),
    .os_i             (osIn),
    .os_o             (osOut),
    .ad_reset_o       (adReset),
    .ad_convst_o      (adConvst),
    .ad_busy_i        (adBusy),
    .spi_start_flag_o (spiStart),
    .data_flag_i      (dataFlag),
    .frame_cnt_o      (frameCnt),
    .overrun_o        (overrun),
    .timeout_o        (timeout)
  );

  // 100 MHz system clock
  always #5 clock = ~clock;

  // Cycle counter referenced by the monitor's interval measurements
  always @(posedge clock) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExpect(input evKind_t kind, input int value);
    expect_t e;
    e.kind  = kind;
    e.value = value;
    scoreQ.push_back(e);
  endtask

  task automatic scoreEvent(input evKind_t kind, input int value);
    expect_t e;
    checks++;
    if (scoreQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected %s event: got %0d, expected no event", kind.name(), value);
    end else begin
      e = scoreQ.pop_front();
      if (kind != e.kind || value != e.value) begin
        errors++;
        $display("[TB] FAIL %s event: got %s=%0d, expected %s=%0d",
                 e.kind.name(), kind.name(), value, e.kind.name(), e.value);
      end
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [2:0] os);
    enable = en;
    osIn   = os;
  endtask

  // which: 0 frame count reaches target, 1 start pulse, 2 timeout pulse, 3 BUSY high
  task automatic waitEvent(input int which, input int target, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clock);
      case (which)
        0:       hit = (int'(frameCnt) == target);
        1:       hit = spiStart;
        2:       hit = timeout;
        3:       hit = adBusy;
        default: hit = 1'b0;
      endcase
    end
    checkOutput(name, int'(hit), 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "AdReset"}, int'(adReset), 1);
    checkOutput({tag, "Convst"}, int'(adConvst), 1);
    checkOutput({tag, "SpiStart"}, int'(spiStart), 0);
    checkOutput({tag, "FrameCnt"}, int'(frameCnt), 0);
    checkOutput({tag, "Overrun"}, int'(overrun), 0);
    checkOutput({tag, "Timeout"}, int'(timeout), 0);
    checkOutput({tag, "Os"}, int'(osOut), 0);
  endtask

  // ADC model: BUSY rises one cycle after the CONVST rising edge and stays high 20 cycles
  initial forever begin
    @(posedge adConvst);
    if (busyEnable) begin
      @(posedge clock);
      #1 adBusy = 1'b1;
      repeat (20) @(posedge clock);
      #1 adBusy = 1'b0;
    end
  end

  // Read-stage model: data_flag pulse readDelay cycles after each start pulse
  initial forever begin
    @(posedge spiStart);
    repeat (readDelay) @(posedge clock);
    #1 dataFlag = 1'b1;
    @(posedge clock);
    #1 dataFlag = 1'b0;
  end

  // Monitor: converts DUT output edges into timed events and scores them
  always @(negedge clock) begin
    if (!rstN) begin
      arCounting  = 1'b0;
      periodValid = 1'b0;
    end else begin
      if (!arCounting && adReset) begin
        arCounting = 1'b1;
        arStart    = cyc;
      end else if (arCounting && !adReset) begin
        arCounting = 1'b0;
        scoreEvent(EV_ADRST, cyc - arStart);
      end
      if (adReset || !enable) periodValid = 1'b0;
      if (prevConvst && !adConvst) begin
        scoreEvent(EV_CVPER, periodValid ? cyc - lastFall : 0);
        lastFall    = cyc;
        periodValid = 1'b1;
      end
      if (!prevConvst && adConvst) begin
        scoreEvent(EV_CVLOW, cyc - lastFall);
        lastRise = cyc;
      end
      if (prevBusy && !adBusy) busyFall = cyc;
      if (!prevSpi && spiStart) scoreEvent(EV_START, cyc - busyFall);
      if (int'(frameCnt) != prevFrame) scoreEvent(EV_FRAME, int'(frameCnt));
      if (!prevTmo && timeout) scoreEvent(EV_TMO, cyc - lastRise);
    end
    prevConvst = adConvst;
    prevBusy   = adBusy;
    prevSpi    = spiStart;
    prevTmo    = timeout;
    prevFrame  = int'(frameCnt);
  end

  // Safety net so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout: got simulation still running, expected finish");
    $fatal(1, "[TB] global time limit reached");
  end

  // Directed scenarios
  initial begin
    bit tmoSeen;

    // Reset values, then the RESET pulse after release
    repeat (3) @(negedge clock);
    checkResetOutputs("rst");
    pushExpect(EV_ADRST, 4);
    @(posedge clock);
    #1 rstN = 1'b1;
    repeat (10) @(negedge clock);
    checkOutput("relAdReset", int'(adReset), 0);
    checkOutput("relConvst", int'(adConvst), 1);

`ifndef AD7606_BUSY_TIMEOUT_EN
    // With the watchdog compiled in at 50 cycles a 40-cycle read could never
    // complete, so the frame scenarios are run only in the default build.

    // Normal frames at the nominal period
    busyEnable = 1'b1;
    readDelay  = 40;
    pushExpect(EV_CVPER, 0);
    pushExpect(EV_CVLOW, 2);
    pushExpect(EV_START, 3);
    pushExpect(EV_FRAME, 1);
    applyStimulus(1'b1, 3'b010);
    waitEvent(0, 1, 300, "waitFrame1");
    pushExpect(EV_CVPER, 100);
    pushExpect(EV_CVLOW, 2);
    pushExpect(EV_START, 3);
    pushExpect(EV_FRAME, 2);
    waitEvent(0, 2, 300, "waitFrame2");
    checkOutput("noOverrunYet", int'(overrun), 0);
    checkOutput("osAfterIdle", int'(osOut), 3'b010);

    // Overrun: a slow read spans a period wrap, next CONV one period later
    readDelay = 120;
    pushExpect(EV_CVPER, 100);
    pushExpect(EV_CVLOW, 2);
    pushExpect(EV_START, 3);
    pushExpect(EV_FRAME, 3);
    waitEvent(0, 3, 300, "waitFrame3");
    checkOutput("overrunSet", int'(overrun), 1);
    readDelay = 40;
    pushExpect(EV_CVPER, 200);
    pushExpect(EV_CVLOW, 2);
    pushExpect(EV_START, 3);
    pushExpect(EV_FRAME, 4);
    waitEvent(0, 4, 300, "waitFrame4");
    checkOutput("overrunSticky", int'(overrun), 1);
    applyStimulus(1'b0, 3'b010);
    repeat (4) @(negedge clock);
    checkOutput("overrunClearedIdle", int'(overrun), 0);
    repeat (150) @(negedge clock);

    // Enable dropped during WAIT_BL; os request held off until IDLE
    pushExpect(EV_CVPER, 0);
    pushExpect(EV_CVLOW, 2);
    pushExpect(EV_START, 3);
    pushExpect(EV_FRAME, 5);
    applyStimulus(1'b1, 3'b010);
    waitEvent(3, 0, 50, "waitBusyHigh");
    repeat (6) @(posedge clock);
    #1 applyStimulus(1'b0, 3'b101);
    waitEvent(1, 0, 100, "waitStartMidFrame");
    checkOutput("osHeldMidFrame", int'(osOut), 3'b010);
    waitEvent(0, 5, 200, "waitFrame5");
    repeat (5) @(negedge clock);
    checkOutput("osUpdatedIdle", int'(osOut), 3'b101);
    checkOutput("overrunAfterFrame5", int'(overrun), 0);
    repeat (150) @(negedge clock);

    // Asynchronous reset during READ
    pushExpect(EV_CVPER, 0);
    pushExpect(EV_CVLOW, 2);
    pushExpect(EV_START, 3);
    applyStimulus(1'b1, 3'b101);
    waitEvent(1, 0, 100, "waitStartBeforeReset");
    repeat (5) @(posedge clock);
    #1 rstN = 1'b0;
    #1 checkResetOutputs("asyncRst");
    applyStimulus(1'b0, 3'b101);
    repeat (3) @(posedge clock);
    pushExpect(EV_ADRST, 4);
    #1 rstN = 1'b1;
    repeat (60) @(negedge clock);
    checkOutput("frameAfterAsyncRst", int'(frameCnt), 0);
    checkOutput("adResetAfterAsyncRst", int'(adReset), 0);
`endif

    // Watchdog: BUSY never rises
    busyEnable = 1'b0;
    pushExpect(EV_CVPER, 0);
    pushExpect(EV_CVLOW, 2);
`ifdef AD7606_BUSY_TIMEOUT_EN
    pushExpect(EV_TMO, 50);
    pushExpect(EV_ADRST, 4);
    applyStimulus(1'b1, 3'b000);
    waitEvent(2, 0, 200, "waitTimeout");
    applyStimulus(1'b0, 3'b000);
    repeat (20) @(negedge clock);
    checkOutput("wdFrameUnchanged", int'(frameCnt), 0);
    checkOutput("wdAdResetDone", int'(adReset), 0);
    checkOutput("wdConvstIdle", int'(adConvst), 1);
`else
    applyStimulus(1'b1, 3'b000);
    tmoSeen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (timeout) tmoSeen = 1'b1;
    end
    checkOutput("noTimeoutPulse", int'(tmoSeen), 0);
    checkOutput("stuckConvstHigh", int'(adConvst), 1);
    checkOutput("stuckNoReset", int'(adReset), 0);
    checkOutput("stuckNoStart", int'(spiStart), 0);
    applyStimulus(1'b0, 3'b000);
`endif

    repeat (5) @(negedge clock);
    checkOutput("scoreQueueEmpty", scoreQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
